cmd_proc_q: RTL and testbench

Next-generation knight command processor. It buffers BLE commands in a parametrised queue and executes them in order: calibrate, move, move+fanfare, tour start. It adds an immediate STOP opcode, saturating ramp limits and a response code byte. It sits between UART_wrapper and the PID/TourCmd/piezo blocks.

---
 rtl/cmd_proc_q.sv | 316 +++++++++++++++++++++++++++++++
 tb/tb_cmd_proc_q.sv | 454 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_proc_q.sv
// Knight command processor: queues BLE commands and runs cal/move/tour/stop in order.
// Latency: clr_cmd_rdy 1 cycle after accept; a queued command dispatches 1 cycle after reaching the head.
// Backpressure: a full queue withholds clr_cmd_rdy until a slot frees; STOP bypasses the queue.

// Command FIFO: power-of-two ring buffer with synchronous flush.
// Latency: a pushed word is visible at head_dat_o the cycle after the push.
// Backpressure: a push into a full FIFO is dropped, so callers gate pushes with full_o.
module cmd_proc_q_fifo #(
    parameter int  W     = 16,
    parameter int  DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_vld_i,
    input  logic [W-1:0] push_dat_i,
    input  logic         pop_i,
    input  logic         flush_i,
    output logic [W-1:0] head_dat_o,
    output logic         full_o,
    output logic         empty_o
);
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] cnt_q;
    logic          do_push;
    logic          do_pop;

    assign full_o     = (cnt_q == CW'(DEPTH));
    assign empty_o    = (cnt_q == '0);
    assign do_push    = push_vld_i & ~full_o;
    assign do_pop     = pop_i & ~empty_o;
    assign head_dat_o = mem_q[rd_ptr_q];

    // Storage needs no reset: only slots below the occupancy count are ever read.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

    // Pointers and occupancy; flush discards everything, push+pop keeps the count.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end
endmodule

module cmd_proc_q #(
    parameter int FRWRD_W   = 10,
    parameter int HEAD_W    = 12,
    parameter int SQ_W      = 3,
    parameter int QDEPTH    = 4,
    parameter int UP_STEP   = 4,
    parameter int DN_STEP   = 8,
    parameter int MAX_FRWRD = 768,
    parameter int NUDGE     = 95,
    parameter int HEAD_TOL  = 48
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [15:0]        cmd,
    input  logic               cmd_rdy,
    output logic               clr_cmd_rdy,
    output logic               send_resp,
    output logic [7:0]         resp,
    output logic               strt_cal,
    input  logic               cal_done,
    input  logic [HEAD_W-1:0]  heading,
    input  logic               heading_rdy,
    input  logic               lftIR,
    input  logic               cntrIR,
    input  logic               rghtIR,
    output logic [HEAD_W-1:0]  error,
    output logic [FRWRD_W-1:0] frwrd,
    output logic               moving,
    output logic               tour_go,
    output logic               fanfare_go,
    output logic               q_full,
    output logic               busy
);
    localparam logic [3:0] OP_CAL      = 4'h0;
    localparam logic [3:0] OP_MOVE     = 4'h2;
    localparam logic [3:0] OP_MOVE_FAN = 4'h3;
    localparam logic [3:0] OP_TOUR     = 4'h4;
    localparam logic [3:0] OP_STOP     = 4'hF;

    localparam logic [7:0] RESP_OK   = 8'hA5;
    localparam logic [7:0] RESP_BAD  = 8'hE1;
    localparam logic [7:0] RESP_STOP = 8'hE2;

    localparam logic [3:0]         SQ_MASK  = 4'((1 << SQ_W) - 1);
    localparam logic [HEAD_W-1:0]  NUDGE_P  = HEAD_W'(NUDGE);
    localparam logic [HEAD_W-1:0]  NUDGE_N  = HEAD_W'(-NUDGE);
    localparam logic [HEAD_W-1:0]  TOL      = HEAD_W'(HEAD_TOL);
    localparam logic [FRWRD_W:0]   MAX_F    = (FRWRD_W+1)'(MAX_FRWRD);
    localparam logic [FRWRD_W:0]   UP_F     = (FRWRD_W+1)'(UP_STEP);
    localparam logic [FRWRD_W-1:0] DN_F     = FRWRD_W'(DN_STEP);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CAL,
        S_ALIGN,
        S_RAMP_UP,
        S_RAMP_DN
    } state_t;

    state_t             state_q;
    logic [15:0]        cmd_q;
    logic [FRWRD_W-1:0] frwrd_q;
    logic [SQ_W:0]      line_q;
    logic               stopped_q;
    logic               clr_q;
    logic               cntr_q;
    logic               send_q;
    logic [7:0]         resp_q;
    logic               cal_q;
    logic               tour_q;
    logic               fan_q;

    logic               is_stop;
    logic               accept;
    logic               push;
    logic               stop_acc;
    logic               pop;
    logic [15:0]        head;
    logic               fifo_full;
    logic               fifo_empty;
    logic               cntr_rise;
    logic [SQ_W:0]      line_tgt;
    logic [HEAD_W-1:0]  desired;
    logic [HEAD_W-1:0]  nudge;
    logic [HEAD_W-1:0]  err;
    logic [HEAD_W-1:0]  err_abs;
    logic               aligned;
    logic [FRWRD_W:0]   up_sum;
    logic [FRWRD_W-1:0] up_sat;
    logic [FRWRD_W-1:0] dn_sat;

    // STOP is taken even with a full queue since it never occupies a slot.
    assign is_stop  = (cmd[15:12] == OP_STOP);
    assign accept   = cmd_rdy & ~clr_q & (~fifo_full | is_stop);
    assign push     = accept & ~is_stop;
    assign stop_acc = accept & is_stop;
    // A STOP arriving in IDLE wins over dispatch so the flushed head is never run.
    assign pop      = (state_q == S_IDLE) & ~fifo_empty & ~stop_acc;

    cmd_proc_q_fifo #(
        .W     (16),
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clk_i      (clk),
        .rst_i      (rst),
        .push_vld_i (push),
        .push_dat_i (cmd),
        .pop_i      (pop),
        .flush_i    (stop_acc),
        .head_dat_o (head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    assign cntr_rise = cntrIR & ~cntr_q;
    assign line_tgt  = (SQ_W+1)'({cmd_q[3:0] & SQ_MASK, 1'b0});

    // Heading error seen by the PID, including the IR wall nudge.
    always_comb begin
        desired = '0;
        if (cmd_q[11:4] != 8'h00) begin
            desired = {cmd_q[11:4], {(HEAD_W-8){1'b1}}};
        end
        nudge = '0;
        if (lftIR && !rghtIR) begin
            nudge = NUDGE_P;
        end else if (rghtIR && !lftIR) begin
            nudge = NUDGE_N;
        end
        err     = heading - desired + nudge;
        err_abs = err[HEAD_W-1] ? (~err + HEAD_W'(1)) : err;
        aligned = (err_abs < TOL);
    end

    // Speed steps computed one bit wider so the ceiling check cannot wrap.
    always_comb begin
        up_sum = {1'b0, frwrd_q} + UP_F;
        up_sat = (up_sum >= MAX_F) ? MAX_F[FRWRD_W-1:0] : up_sum[FRWRD_W-1:0];
        dn_sat = (frwrd_q >= DN_F) ? (frwrd_q - DN_F) : '0;
    end

    // Intake handshake pulse and cntrIR edge history.
    always_ff @(posedge clk) begin
        if (rst) begin
            clr_q  <= 1'b0;
            cntr_q <= 1'b0;
        end else begin
            clr_q  <= accept;
            cntr_q <= cntrIR;
        end
    end

    // Command sequencer: dispatch, calibration wait, align, ramps, responses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cmd_q     <= '0;
            frwrd_q   <= '0;
            line_q    <= '0;
            stopped_q <= 1'b0;
            send_q    <= 1'b0;
            resp_q    <= '0;
            cal_q     <= 1'b0;
            tour_q    <= 1'b0;
            fan_q     <= 1'b0;
        end else begin
            send_q <= 1'b0;
            cal_q  <= 1'b0;
            tour_q <= 1'b0;
            fan_q  <= 1'b0;
            if (((state_q == S_ALIGN) || (state_q == S_RAMP_UP)) && cntr_rise) begin
                line_q <= line_q + (SQ_W+1)'(1);
            end
            case (state_q)
                S_IDLE: begin
                    if (stop_acc) begin
                        send_q <= 1'b1;
                        resp_q <= RESP_OK;
                    end else if (!fifo_empty) begin
                        case (head[15:12])
                            OP_CAL: begin
                                cal_q   <= 1'b1;
                                state_q <= S_CAL;
                            end
                            OP_TOUR: begin
                                tour_q <= 1'b1;
                            end
                            OP_MOVE, OP_MOVE_FAN: begin
                                cmd_q     <= head;
                                frwrd_q   <= '0;
                                line_q    <= '0;
                                stopped_q <= 1'b0;
                                state_q   <= S_ALIGN;
                            end
                            default: begin
                                send_q <= 1'b1;
                                resp_q <= RESP_BAD;
                            end
                        endcase
                    end
                end
                S_CAL: begin
                    if (cal_done) begin
                        send_q  <= 1'b1;
                        resp_q  <= RESP_OK;
                        state_q <= S_IDLE;
                    end
                end
                S_ALIGN: begin
                    if (stop_acc) begin
                        stopped_q <= 1'b1;
                        state_q   <= S_RAMP_DN;
                    end else if (aligned) begin
                        state_q <= S_RAMP_UP;
                    end
                end
                S_RAMP_UP: begin
                    if (stop_acc) begin
                        stopped_q <= 1'b1;
                        state_q   <= S_RAMP_DN;
                    end else if (line_q == line_tgt) begin
                        fan_q   <= (cmd_q[15:12] == OP_MOVE_FAN);
                        state_q <= S_RAMP_DN;
                    end else if (heading_rdy) begin
                        frwrd_q <= up_sat;
                    end
                end
                S_RAMP_DN: begin
                    if (frwrd_q == '0) begin
                        send_q  <= 1'b1;
                        resp_q  <= stopped_q ? RESP_STOP : RESP_OK;
                        state_q <= S_IDLE;
                    end else if (heading_rdy) begin
                        frwrd_q <= dn_sat;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign clr_cmd_rdy = clr_q;
    assign send_resp   = send_q;
    assign resp        = resp_q;
    assign strt_cal    = cal_q;
    assign tour_go     = tour_q;
    assign fanfare_go  = fan_q;
    assign error       = err;
    assign frwrd       = frwrd_q;
    assign moving      = (state_q == S_RAMP_UP) || (state_q == S_RAMP_DN);
    assign q_full      = fifo_full;
    assign busy        = (state_q != S_IDLE) || !fifo_empty;
endmodule

// File: tb/tb_cmd_proc_q.sv
// Bench for cmd_proc_q: drives BLE commands, sensor strobes and IR edges.
// Pulse outputs (resp/strt_cal/tour_go/fanfare_go) are matched in order against an event queue.
// Every advance of time goes through tick(), so no pulse can slip past the event queue.
module tb_cmd_proc_q;
    localparam int HEAD_W  = 12;
    localparam int FRWRD_W = 10;

    localparam logic [15:0] EV_CAL  = 16'h0200;
    localparam logic [15:0] EV_TOUR = 16'h0300;
    localparam logic [15:0] EV_FAN  = 16'h0400;

    logic               clk;
    logic               rst;
    logic [15:0]        cmd;
    logic               cmd_rdy;
    logic               clr_cmd_rdy;
    logic               send_resp;
    logic [7:0]         resp;
    logic               strt_cal;
    logic               cal_done;
    logic [HEAD_W-1:0]  heading;
    logic               heading_rdy;
    logic               lftIR;
    logic               cntrIR;
    logic               rghtIR;
    logic [HEAD_W-1:0]  error;
    logic [FRWRD_W-1:0] frwrd;
    logic               moving;
    logic               tour_go;
    logic               fanfare_go;
    logic               q_full;
    logic               busy;

    int checks = 0;
    int errors = 0;
    logic [15:0] sb[$];

    cmd_proc_q dut (
        .clk         (clk),
        .rst         (rst),
        .cmd         (cmd),
        .cmd_rdy     (cmd_rdy),
        .clr_cmd_rdy (clr_cmd_rdy),
        .send_resp   (send_resp),
        .resp        (resp),
        .strt_cal    (strt_cal),
        .cal_done    (cal_done),
        .heading     (heading),
        .heading_rdy (heading_rdy),
        .lftIR       (lftIR),
        .cntrIR      (cntrIR),
        .rghtIR      (rghtIR),
        .error       (error),
        .frwrd       (frwrd),
        .moving      (moving),
        .tour_go     (tour_go),
        .fanfare_go  (fanfare_go),
        .q_full      (q_full),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic sb_match(input logic [15:0] got, input string name);
        logic [15:0] e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s unexpected event got %h required none", name, got);
        end else begin
            e = sb.pop_front();
            if (got !== e) begin
                errors++;
                $display("FAIL %s event order got %h required %h", name, got, e);
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (send_resp === 1'b1)  sb_match({8'h01, resp}, "resp");
        if (strt_cal === 1'b1)   sb_match(EV_CAL, "strt_cal");
        if (tour_go === 1'b1)    sb_match(EV_TOUR, "tour_go");
        if (fanfare_go === 1'b1) sb_match(EV_FAN, "fanfare_go");
    endtask

    task automatic send_cmd(input logic [15:0] c, input int hold, output int waited);
        cmd = c;
        cmd_rdy = 1'b1;
        waited = 0;
        do begin
            tick();
            waited++;
        end while (clr_cmd_rdy !== 1'b1 && waited < 20);
        checks++;
        if (clr_cmd_rdy !== 1'b1) begin
            errors++;
            $display("FAIL cmd_ack got no clr_cmd_rdy for %h within %0d cycles", c, waited);
        end
        repeat (hold) tick();
        cmd_rdy = 1'b0;
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s pending events got %0d required 0 (next %h)", name, sb.size(), sb[0]);
        end
    endtask

    task automatic hr_pulse();
        heading_rdy = 1'b1;
        tick();
        heading_rdy = 1'b0;
        tick();
    endtask

    task automatic cntr_edge();
        cntrIR = 1'b1;
        tick();
        cntrIR = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if ({clr_cmd_rdy, send_resp, strt_cal, tour_go, fanfare_go, moving, q_full, busy} !== 8'h00) begin
            errors++;
            $display("FAIL reset_flags got %b required 00000000",
                     {clr_cmd_rdy, send_resp, strt_cal, tour_go, fanfare_go, moving, q_full, busy});
        end
        checks++;
        if (resp !== 8'h00) begin errors++; $display("FAIL reset_resp got %h required 00", resp); end
        checks++;
        if (frwrd !== '0) begin errors++; $display("FAIL reset_frwrd got %0d required 0", frwrd); end
        checks++;
        if (error !== '0) begin errors++; $display("FAIL reset_error got %h required 000", error); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_cal();
        int w;
        sb.push_back(EV_CAL);
        sb.push_back({8'h01, 8'hA5});
        send_cmd(16'h0000, 1, w);
        checks++;
        if (w !== 1) begin errors++; $display("FAIL cal_ack_latency got %0d required 1", w); end
        checks++;
        if (clr_cmd_rdy !== 1'b0) begin errors++; $display("FAIL cal_ack_single got %b required 0", clr_cmd_rdy); end
        checks++;
        if (sb.size() !== 1) begin errors++; $display("FAIL cal_strt_seen got %0d pending required 1", sb.size()); end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL cal_busy got %b required 1", busy); end
        repeat (3) tick();
        cal_done = 1'b1;
        tick();
        cal_done = 1'b0;
        checks++;
        if (sb.size() !== 0) begin errors++; $display("FAIL cal_resp_seen got %0d pending required 0", sb.size()); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL cal_busy_falls got %b required 0", busy); end
        repeat (4) tick();
    endtask

    task automatic test_move();
        int w;
        int exp_f = 0;
        heading = '0;
        sb.push_back({8'h01, 8'hA5});
        send_cmd(16'h2002, 0, w);
        tick();
        tick();
        checks++;
        if (moving !== 1'b1 || error !== '0) begin
            errors++;
            $display("FAIL move_ramp_entry got moving=%b error=%h required moving=1 error=000", moving, error);
        end
        for (int i = 0; i < 5; i++) begin
            hr_pulse();
            exp_f = (exp_f + 4 > 768) ? 768 : exp_f + 4;
            checks++;
            if (frwrd !== FRWRD_W'(exp_f)) begin errors++; $display("FAIL move_ramp_up got %0d required %0d", frwrd, exp_f); end
        end
        repeat (4) cntr_edge();
        checks++;
        if (moving !== 1'b1 || frwrd !== FRWRD_W'(exp_f)) begin
            errors++;
            $display("FAIL move_ramp_dn_entry got moving=%b frwrd=%0d required moving=1 frwrd=%0d", moving, frwrd, exp_f);
        end
        while (exp_f != 0) begin
            hr_pulse();
            exp_f = (exp_f >= 8) ? exp_f - 8 : 0;
            checks++;
            if (frwrd !== FRWRD_W'(exp_f)) begin errors++; $display("FAIL move_ramp_dn got %0d required %0d", frwrd, exp_f); end
        end
        wait_drain(10, "move_resp");
        checks++;
        if (moving !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL move_done got moving=%b busy=%b required 0 0", moving, busy);
        end
    endtask

    task automatic test_saturate();
        int w;
        int exp_f = 0;
        heading = '0;
        sb.push_back({8'h01, 8'hA5});
        send_cmd(16'h2001, 0, w);
        tick();
        tick();
        for (int i = 0; i < 200; i++) begin
            hr_pulse();
            exp_f = (exp_f + 4 > 768) ? 768 : exp_f + 4;
            checks++;
            if (frwrd !== FRWRD_W'(exp_f)) begin errors++; $display("FAIL sat_up step %0d got %0d required %0d", i, frwrd, exp_f); end
        end
        repeat (2) cntr_edge();
        while (exp_f != 0) begin
            hr_pulse();
            exp_f = (exp_f >= 8) ? exp_f - 8 : 0;
            checks++;
            if (frwrd !== FRWRD_W'(exp_f)) begin errors++; $display("FAIL sat_dn got %0d required %0d", frwrd, exp_f); end
        end
        wait_drain(10, "sat_resp");
    endtask

    task automatic test_fanfare();
        int w;
        heading = '0;
        sb.push_back(EV_FAN);
        sb.push_back({8'h01, 8'hA5});
        send_cmd(16'h3001, 0, w);
        tick();
        tick();
        hr_pulse();
        hr_pulse();
        cntr_edge();
        checks++;
        if (sb.size() !== 2) begin errors++; $display("FAIL fan_early got %0d pending required 2", sb.size()); end
        cntr_edge();
        checks++;
        if (sb.size() !== 1) begin errors++; $display("FAIL fan_at_edge2 got %0d pending required 1", sb.size()); end
        hr_pulse();
        checks++;
        if (frwrd !== '0) begin errors++; $display("FAIL fan_ramp_dn got %0d required 0", frwrd); end
        wait_drain(10, "fan_resp");
        repeat (4) tick();
    endtask

    task automatic test_queue();
        int  w;
        int  n;
        logic got_clr;
        heading = '0;
        sb.push_back({8'h01, 8'hA5});
        sb.push_back(EV_TOUR);
        sb.push_back({8'h01, 8'hE1});
        sb.push_back(EV_CAL);
        sb.push_back({8'h01, 8'hA5});
        sb.push_back(EV_TOUR);
        sb.push_back({8'h01, 8'hE1});
        send_cmd(16'h2001, 0, w);
        tick();
        tick();
        send_cmd(16'h4000, 0, w);
        send_cmd(16'h7000, 0, w);
        send_cmd(16'h0000, 0, w);
        send_cmd(16'h4000, 0, w);
        tick();
        checks++;
        if (q_full !== 1'b1) begin errors++; $display("FAIL queue_full got %b required 1", q_full); end
        cmd = 16'h6000;
        cmd_rdy = 1'b1;
        got_clr = 1'b0;
        repeat (5) begin
            tick();
            got_clr = got_clr | clr_cmd_rdy;
        end
        checks++;
        if (got_clr !== 1'b0 || q_full !== 1'b1) begin
            errors++;
            $display("FAIL queue_hold got clr=%b q_full=%b required clr=0 q_full=1", got_clr, q_full);
        end
        repeat (2) cntr_edge();
        n = 0;
        while (clr_cmd_rdy !== 1'b1 && n < 30) begin
            tick();
            n++;
        end
        cmd_rdy = 1'b0;
        checks++;
        if (clr_cmd_rdy !== 1'b1) begin errors++; $display("FAIL queue_fifth_ack got %b required 1", clr_cmd_rdy); end
        n = 0;
        while (sb.size() > 3 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (sb.size() !== 3) begin errors++; $display("FAIL queue_cal_reached got %0d pending required 3", sb.size()); end
        cal_done = 1'b1;
        tick();
        cal_done = 1'b0;
        wait_drain(20, "queue_order");
        tick();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL queue_idle got busy=%b required 0", busy); end
    endtask

    task automatic test_stop();
        int w;
        int exp_f = 0;
        heading = '0;
        sb.push_back({8'h01, 8'hE2});
        send_cmd(16'h2002, 0, w);
        tick();
        tick();
        repeat (3) begin
            hr_pulse();
            exp_f = exp_f + 4;
        end
        send_cmd(16'h4000, 0, w);
        send_cmd(16'h7000, 0, w);
        send_cmd(16'hF000, 0, w);
        checks++;
        if (moving !== 1'b1 || frwrd !== FRWRD_W'(exp_f) || q_full !== 1'b0) begin
            errors++;
            $display("FAIL stop_entry got moving=%b frwrd=%0d q_full=%b required 1 %0d 0", moving, frwrd, q_full, exp_f);
        end
        while (exp_f != 0) begin
            hr_pulse();
            exp_f = (exp_f >= 8) ? exp_f - 8 : 0;
            checks++;
            if (frwrd !== FRWRD_W'(exp_f)) begin errors++; $display("FAIL stop_ramp_dn got %0d required %0d", frwrd, exp_f); end
        end
        wait_drain(10, "stop_resp");
        repeat (20) tick();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL stop_flushed got busy=%b required 0", busy); end
        sb.push_back({8'h01, 8'hA5});
        send_cmd(16'hF000, 0, w);
        wait_drain(5, "stop_idle_resp");
    endtask

    task automatic test_error();
        int w;
        logic [HEAD_W-1:0] des;
        logic [HEAD_W-1:0] nud;
        logic [HEAD_W-1:0] exp_e;
        des = {8'h40, 4'hF};
        heading = 12'h100;
        sb.push_back({8'h01, 8'hA5});
        send_cmd(16'h2400, 0, w);
        tick();
        tick();
        for (int k = 0; k < 4; k++) begin
            lftIR  = ((k & 1) != 0);
            rghtIR = ((k & 2) != 0);
            tick();
            if (lftIR && !rghtIR)      nud = 12'd95;
            else if (rghtIR && !lftIR) nud = -12'd95;
            else                       nud = '0;
            exp_e = heading - des + nud;
            checks++;
            if (error !== exp_e) begin
                errors++;
                $display("FAIL err_nudge l=%b r=%b got %h required %h", lftIR, rghtIR, error, exp_e);
            end
        end
        lftIR  = 1'b0;
        rghtIR = 1'b0;
        heading = des + 12'd48;
        repeat (3) tick();
        checks++;
        if (moving !== 1'b0 || error !== 12'd48) begin
            errors++;
            $display("FAIL align_pos48 got moving=%b error=%h required 0 030", moving, error);
        end
        heading = des - 12'd48;
        repeat (3) tick();
        checks++;
        if (moving !== 1'b0) begin errors++; $display("FAIL align_neg48 got moving=%b required 0", moving); end
        heading = des + 12'd47;
        tick();
        checks++;
        if (moving !== 1'b1) begin errors++; $display("FAIL align_pos47 got moving=%b required 1", moving); end
        wait_drain(10, "sq0_resp");
        checks++;
        if (frwrd !== '0 || moving !== 1'b0) begin
            errors++;
            $display("FAIL sq0_done got frwrd=%0d moving=%b required 0 0", frwrd, moving);
        end
        heading = '0;
        sb.push_back({8'h01, 8'hE1});
        send_cmd(16'h7000, 0, w);
        wait_drain(10, "bad_opcode");
        tick();
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL bad_opcode_idle got busy=%b required 0", busy); end
    endtask

    task automatic test_reset_mid_move();
        int w;
        heading = '0;
        send_cmd(16'h2004, 0, w);
        tick();
        tick();
        repeat (5) hr_pulse();
        checks++;
        if (frwrd !== FRWRD_W'(20)) begin errors++; $display("FAIL rst_mid_pre got %0d required 20", frwrd); end
        rst = 1'b1;
        tick();
        checks++;
        if (frwrd !== '0 || moving !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid got frwrd=%0d moving=%b busy=%b required 0 0 0", frwrd, moving, busy);
        end
        rst = 1'b0;
        repeat (5) tick();
    endtask

    initial begin
        rst         = 1'b1;
        cmd         = '0;
        cmd_rdy     = 1'b0;
        cal_done    = 1'b0;
        heading     = '0;
        heading_rdy = 1'b0;
        lftIR       = 1'b0;
        cntrIR      = 1'b0;
        rghtIR      = 1'b0;
        test_reset();
        test_cal();
        test_move();
        test_saturate();
        test_fanfare();
        test_queue();
        test_stop();
        test_error();
        test_reset_mid_move();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
